// File: rtl/mcycle_sequencer.sv
// mcycle_sequencer: holds IR and step counter, runs one req/ack bus transaction per decoder
// micro-step, strobes commit to the datapath, and halts with a sticky error code on faults.
module mcycle_sequencer #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned COUNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    output logic [7:0]         opcode,
    output logic [2:0]         step,
    input  logic               done,
    input  logic               is_cond,
    input  logic [2:0]         next_cond,
    input  logic               write_mem,
    input  logic               cc_met,
    output logic               mem_req,
    output logic               mem_we,
    input  logic               mem_ack,
    input  logic [7:0]         mem_rdata,
    output logic               commit,
    output logic               boot,
    output logic               ir_load,
    output logic [COUNT_W-1:0] instr_count,
    output logic               halted,
    output logic [1:0]         err_code
);
    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_STEP    = 2'd2;
    localparam logic [1:0] ERR_WDONE   = 2'd3;

    localparam int unsigned        WAIT_W    = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    logic [1:0]         state_q, state_d;
    logic [7:0]         ir_q, ir_d;
    logic [2:0]         step_q, step_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [1:0]         err_q, err_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               timeout;

    // Control outputs are gated by reset so an ack during reset cannot commit.
    assign mem_req     = !reset && (state_q == S_BOOT || state_q == S_BUS);
    assign mem_we      = mem_req && (state_q == S_BUS) && write_mem;
    assign commit      = mem_req && mem_ack;
    assign boot        = !reset && (state_q == S_BOOT);
    assign ir_load     = commit && ((state_q == S_BOOT) || done);
    assign halted      = !reset && (state_q == S_HALT);
    assign opcode      = ir_q;
    assign step        = step_q;
    assign instr_count = count_q;
    assign err_code    = err_q;

    assign timeout = (MAX_WAIT != 0) && mem_req && !mem_ack && (wait_q == WAIT_LAST);

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        step_d  = step_q;
        count_d = count_q;
        err_d   = err_q;
        wait_d  = wait_q;
        if (commit) begin
            wait_d = '0;
            if (state_q == S_BOOT) begin
                ir_d    = mem_rdata;
                step_d  = '0;
                state_d = S_BUS;
            end else if (done && write_mem) begin
                err_d   = ERR_WDONE;
                state_d = S_HALT;
            end else if (done) begin
                ir_d    = mem_rdata;
                step_d  = '0;
                count_d = count_q + COUNT_W'(1);
            end else if (is_cond && !cc_met) begin
                step_d = next_cond;
            end else if (step_q == 3'd7) begin
                err_d   = ERR_STEP;
                state_d = S_HALT;
            end else begin
                step_d = step_q + 3'd1;
            end
        end else if (timeout) begin
            err_d   = ERR_TIMEOUT;
            state_d = S_HALT;
            wait_d  = '0;
        end else if (mem_req) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_BOOT;
            ir_q    <= '0;
            step_q  <= '0;
            count_q <= '0;
            err_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            step_q  <= step_d;
            count_q <= count_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end
endmodule

// File: tb/tb_mcycle_sequencer.sv
// Bench for mcycle_sequencer: directed scenarios plus random decoder/bus traffic,
// all checked cycle by cycle against an instruction-level reference model.
module tb_mcycle_sequencer;
    localparam int unsigned MW = 4;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    opcode;
    logic [2:0]    step;
    logic          done = 1'b0, is_cond = 1'b0, write_mem = 1'b0, cc_met = 1'b0;
    logic [2:0]    next_cond = 3'd0;
    logic          mem_req, mem_we, mem_ack = 1'b0, commit, boot, ir_load, halted;
    logic [7:0]    mem_rdata = 8'h00;
    logic [CW-1:0] instr_count;
    logic [1:0]    err_code;

    always #5 clk = ~clk;

    mcycle_sequencer #(.MAX_WAIT(MW), .COUNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .step(step), .done(done),
        .is_cond(is_cond), .next_cond(next_cond), .write_mem(write_mem), .cc_met(cc_met),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .commit(commit), .boot(boot), .ir_load(ir_load), .instr_count(instr_count),
        .halted(halted), .err_code(err_code)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: fetching flag, halted flag, IR, step, retired count, error, wait cycles.
    bit            m_boot = 1'b1, m_halt = 1'b0;
    logic [7:0]    m_ir = 8'h00;
    logic [2:0]    m_step = 3'd0;
    logic [CW-1:0] m_cnt = '0;
    logic [1:0]    m_err = 2'd0;
    int            m_wait = 0;

    bit            d_done, d_cond, d_wr;
    logic [2:0]    d_nc;
    int            n_irload = 0, n_we = 0, n_req = 0, n_commit = 0;
    bit            s_boot, s_halt;

    task automatic cycle(input bit rst, input bit ack, input logic [7:0] rd, input bit cc);
        bit e_req, e_we, e_commit, e_boot, e_irl, e_halt;
        @(negedge clk);
        reset = rst; mem_ack = ack; mem_rdata = rd; cc_met = cc;
        done = d_done; is_cond = d_cond; next_cond = d_nc; write_mem = d_wr;
        #1;
        e_req    = !rst && !m_halt;
        e_commit = e_req && ack;
        e_we     = e_req && !m_boot && d_wr;
        e_boot   = !rst && m_boot;
        e_irl    = e_commit && (m_boot || d_done);
        e_halt   = !rst && m_halt;
        check("ctl", {mem_req, mem_we, commit, boot, ir_load, halted},
              {e_req, e_we, e_commit, e_boot, e_irl, e_halt});
        check("arch", {opcode, step, instr_count, err_code}, {m_ir, m_step, m_cnt, m_err});
        n_irload += int'(ir_load); n_we += int'(mem_we);
        n_req += int'(mem_req); n_commit += int'(commit);
        s_boot = boot; s_halt = halted;
        @(posedge clk);
        if (rst) begin
            m_boot = 1; m_halt = 0; m_ir = 8'h00; m_step = 0; m_cnt = 0; m_err = 0; m_wait = 0;
        end else if (!m_halt) begin
            if (ack) begin
                m_wait = 0;
                if (m_boot) begin m_boot = 0; m_ir = rd; m_step = 0; end
                else if (d_done && d_wr) begin m_err = 3; m_halt = 1; end
                else if (d_done) begin m_ir = rd; m_step = 0; m_cnt = m_cnt + 1'b1; end
                else if (d_cond && !cc) m_step = d_nc;
                else if (m_step == 7) begin m_err = 2; m_halt = 1; end
                else m_step = m_step + 1'b1;
            end else if (m_wait == int'(MW) - 1) begin
                m_err = 1; m_halt = 1; m_boot = 0; m_wait = 0;
            end else begin
                m_wait++;
            end
        end
    endtask

    task automatic dec_clear();
        d_done = 0; d_cond = 0; d_wr = 0; d_nc = 3'd0;
    endtask

    task automatic boot_to(input logic [7:0] op);
        dec_clear();
        cycle(1, 0, 8'h00, 0);
        cycle(0, 1, op, 0);
    endtask

    logic [5:0] tab [0:2047];
    logic [5:0] w;
    int         ack_pct;

    initial begin
        dec_clear();
        // Boot then a two-step instruction on a zero-wait bus.
        cycle(1, 0, 8'h00, 0);
        n_irload = 0;
        cycle(0, 1, 8'h3E, 0);
        #1 check("boot_op", opcode, 8'h3E);
        check("boot_step", step, 0);
        cycle(0, 1, 8'h99, 0);
        d_done = 1;
        cycle(0, 1, 8'h42, 0);
        #1 check("fetch_op", opcode, 8'h42);
        check("count1", instr_count, 1);
        check("irload_pulses", n_irload, 2);

        // Memory write step then final read, each acked after 3 wait cycles.
        boot_to(8'h70);
        n_we = 0; n_commit = 0;
        d_wr = 1;
        repeat (3) cycle(0, 0, 8'h00, 0);
        cycle(0, 1, 8'h00, 0);
        d_wr = 0; d_done = 1;
        repeat (3) cycle(0, 0, 8'h00, 0);
        cycle(0, 1, 8'h01, 0);
        #1 check("we_cycles", n_we, 4);
        check("slow_commits", n_commit, 2);
        check("slow_op", opcode, 8'h01);

        // Conditional step, condition unsatisfied then satisfied.
        for (int c = 0; c < 2; c++) begin
            boot_to(8'h20);
            cycle(0, 1, 8'h00, 0);
            d_cond = 1; d_nc = 3'd5;
            cycle(0, 1, 8'h00, c[0]);
            #1 check("cond_step", step, (c == 0) ? 5 : 2);
        end

        // Bus timeout, then reset recovery.
        boot_to(8'h10);
        n_req = 0;
        repeat (6) cycle(0, 0, 8'h00, 0);
        check("req_cycles", n_req, 4);
        #1 check("to_halt", {halted, err_code}, {1'b1, 2'd1});
        cycle(1, 0, 8'h00, 0);
        #1 check("rst_err", err_code, 0);
        cycle(0, 0, 8'h00, 0);
        check("rst_boot", s_boot, 1);

        // Step overflow out of step 7.
        boot_to(8'h33);
        cycle(0, 1, 8'h00, 0);
        d_cond = 1; d_nc = 3'd7;
        cycle(0, 1, 8'h00, 0);
        d_cond = 0;
        cycle(0, 1, 8'h00, 0);
        #1 check("ovf", {halted, err_code, step}, {1'b1, 2'd2, 3'd7});

        // Write on a done step.
        boot_to(8'h55);
        d_done = 1; d_wr = 1;
        cycle(0, 1, 8'hAA, 0);
        #1 check("wdone", {halted, err_code, opcode}, {1'b1, 2'd3, 8'h55});

        // Reset arriving together with the ack of a pending read.
        boot_to(8'h66);
        cycle(0, 0, 8'h00, 0);
        n_commit = 0; n_irload = 0;
        cycle(1, 1, 8'hEE, 0);
        check("rst_ack", {n_commit[3:0], n_irload[3:0]}, 8'h00);
        #1 check("rst_ir", opcode, 8'h00);
        cycle(0, 0, 8'h00, 0);
        check("rst_boot2", s_boot, 1);

        // Random decoder table and bus behaviour.
        foreach (tab[i])
            tab[i] = {($urandom % 3 == 0), ($urandom % 4 == 0), 3'($urandom), ($urandom % 5 == 0)};
        ack_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) ack_pct = 20 + int'($urandom % 81);
            w = tab[{m_ir, m_step}];
            d_done = w[5]; d_cond = w[4]; d_nc = w[3:1]; d_wr = w[0];
            cycle(($urandom % 64 == 0) || (m_halt && $urandom % 4 == 0),
                  int'($urandom % 100) < ack_pct, 8'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
